mux_rr_param: RTL
=================

Name: mux_rr_param

Overview:
- Parametrised N-to-1 stream multiplexer, N = 2**bitsel, each input WD bits wide.
- Per-input valid/ready handshake and round-robin arbitration.
- One registered output stage.
- Merges several producer streams onto one consumer bus in lab datapaths.
- Replaces direct sel-driven muxing where sources are bursty and must not be dropped.

Parameters:
WD, 8, data width of every input and of the output
bitsel, 2, select width; number of inputs N = 2**bitsel (bitsel >= 1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  [WD-1:0] x 2**bitsel (unpacked array)  per-input data
in_valid  input  [2**bitsel-1:0]  per-input valid
in_ready  output  [2**bitsel-1:0]  per-input ready (combinational)
out_data  output  [WD-1:0]  registered output data
out_valid  output  1  registered output valid
out_sel  output  [bitsel-1:0]  index of the input that sourced out_data
out_ready  input  1  downstream ready

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr = N-1, so input 0 has highest priority first.
- Transfer rule: a beat moves on any handshake when valid&ready are both 1 at a rising edge.
- load = ~out_valid | out_ready. The output register accepts a new beat whenever it is empty or being drained this cycle.
- Arbitration (combinational): grant = first i with in_valid[i]=1, searching ptr+1, ptr+2, ... modulo N. No valid input means no grant.
- Search wrap is mod N: with ptr=N-1 the search starts at 0.
- in_ready[i] = load & grant[i]. At most one bit of in_ready is set. in_ready must not depend on in_valid of the granted input beyond arbitration.
- On an accepted beat from input g: out_data<=in_data[g], out_sel<=g, out_valid<=1, ptr<=g.
- If load=1 and there is no grant: out_valid<=0; out_data and out_sel hold their values.
- If out_valid=1 and out_ready=0: out_data, out_sel and out_valid hold; all in_ready=0; ptr holds.
- Latency: 1 cycle input-to-output.
- Throughput: 1 beat/cycle sustained with out_ready held at 1.
- Fairness: with all N inputs continuously valid, grants rotate 0,1,...,N-1,0,... with no input granted twice before every other valid input has been granted once.
- Simultaneous drain and fill: out_ready=1 with a pending grant replaces the register in the same edge, with no bubble.
- Reset mid-operation: the in-flight beat is discarded; ptr returns to N-1.
- Inputs must hold in_data/in_valid until accepted. The block does not check this.

Optional Feature:
- Macro MUX_RR_LOCK_EN.
- When defined, adds ports in_last input [2**bitsel-1:0] and out_last output 1 (registered; reset 0).
- After a beat is accepted from input g with in_last[g]=0, the grant is locked to g until a beat with in_last[g]=1 is accepted. Other inputs get in_ready=0 even if g is idle.
- out_last mirrors the accepted in_last[g].
- ptr updates only on the last beat.
- Reset clears the lock.
- Undefined: no in_last/out_last ports; every beat is arbitrated independently as above.

Test Plan:
- Reset, then single source: WD=8, bitsel=2, rst_n low 3 cycles. Check out_valid=0, out_data=0, out_sel=0. Release; in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100 same cycle; next cycle out_valid=1, out_data=8'hA5, out_sel=2.
- All-valid fairness: in_valid=4'b1111 for 8 cycles, out_ready=1, in_data[i]=8'h10+i -> out_sel sequence 0,1,2,3,0,1,2,3; out_data 10,11,12,13,10,...; no idle cycles.
- Backpressure: out_valid=1, out_data=8'h11, out_ready=0 for 4 cycles with in_valid=4'b1111 -> out_data stays 8'h11, in_ready=0; on out_ready=1 next grant is input 2 (ptr=1) in the same edge.
- Sparse wrap: ptr=3, in_valid=4'b1010 -> grant input 1; then ptr=1 -> grant input 3; then ptr=3 -> grant input 1.
- Async reset mid-stream: assert rst_n low between clock edges while out_valid=1 -> out_valid=0 immediately; after release, with in_valid=4'b1111, first out_sel=0.
- MUX_RR_LOCK_EN defined: input 1 sends 3 beats (in_last 0,0,1) while in_valid=4'b1111 -> out_sel=1,1,1 with in_ready[0,2,3]=0 throughout; the next grant is input 2.

Source files
------------

// File: rtl/mux_rr_param.sv
// mux_rr_param: N-to-1 valid/ready stream multiplexer with round-robin
// arbitration and a single registered output stage (N = 2**bitsel).
// Optional packet locking is compiled in with `define MUX_RR_LOCK_EN. It adds
// in_last/out_last and holds the grant on one input until its last beat.
module mux_rr_param #(
  parameter int WD     = 8,
  parameter int bitsel = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WD-1:0]              in_data [(1<<bitsel)],
  input  logic [(1<<bitsel)-1:0]     in_valid,
  output logic [(1<<bitsel)-1:0]     in_ready,
`ifdef MUX_RR_LOCK_EN
  input  logic [(1<<bitsel)-1:0]     in_last,
  output logic                       out_last,
`endif
  output logic [WD-1:0]              out_data,
  output logic                       out_valid,
  output logic [bitsel-1:0]          out_sel,
  input  logic                       out_ready
);

  localparam int N = 1 << bitsel;

  logic [WD-1:0]     out_data_reg;
  logic              out_valid_reg;
  logic [bitsel-1:0] out_sel_reg;
  logic [bitsel-1:0] ptr_reg;

  logic              load;
  logic              grant_any;
  logic [bitsel-1:0] grant_idx;
  logic [bitsel-1:0] search_idx;

`ifdef MUX_RR_LOCK_EN
  logic              out_last_reg;
  logic              lock_reg;
  logic [bitsel-1:0] lock_sel_reg;
`endif

  // The output register can take a new beat when empty or draining this cycle.
  assign load = ~out_valid_reg | out_ready;

  // Round-robin search starting just after the last granted input, wrapping mod N.
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    search_idx = '0;
    for (int k = 1; k <= N; k++) begin
      search_idx = ptr_reg + k[bitsel-1:0];
      if (!grant_any && in_valid[search_idx]) begin
        grant_any = 1'b1;
        grant_idx = search_idx;
      end
    end
`ifdef MUX_RR_LOCK_EN
    // While a packet is open only its owner may be granted, even when idle.
    if (lock_reg) begin
      grant_any = in_valid[lock_sel_reg];
      grant_idx = lock_sel_reg;
    end
`endif
  end

  // One-hot ready: only the granted input sees ready, and only when we can load.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign in_ready[gi] = load & grant_any & (grant_idx == bitsel'(gi));
    end
  endgenerate

  // Output stage, round-robin pointer and (optionally) lock state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_sel_reg   <= '0;
      ptr_reg       <= '1;
`ifdef MUX_RR_LOCK_EN
      out_last_reg  <= 1'b0;
      lock_reg      <= 1'b0;
      lock_sel_reg  <= '0;
`endif
    end else if (load) begin
      if (grant_any) begin
        out_data_reg  <= in_data[grant_idx];
        out_sel_reg   <= grant_idx;
        out_valid_reg <= 1'b1;
`ifdef MUX_RR_LOCK_EN
        out_last_reg  <= in_last[grant_idx];
        if (in_last[grant_idx]) begin
          lock_reg <= 1'b0;
          ptr_reg  <= grant_idx;
        end else begin
          lock_reg     <= 1'b1;
          lock_sel_reg <= grant_idx;
        end
`else
        ptr_reg       <= grant_idx;
`endif
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_sel   = out_sel_reg;
`ifdef MUX_RR_LOCK_EN
  assign out_last  = out_last_reg;
`endif

endmodule
